// File: rtl/lockin_pkg.sv
// -----------------------------------------------------------------------------
// lockin_pkg
// Shared definitions for the lock-in integrate-and-dump path.
//   state_t      : integrator FSM states (IDLE, ACUM)
//   Q_IN_DEF     : default product width, shared with the multiplier instance
//   N_WIDTH_DEF  : default sample-count register width
//   ACC_W        : accumulator / frame-sum width for the default widths
// -----------------------------------------------------------------------------
package lockin_pkg;

   localparam int Q_IN_DEF    = 30;
   localparam int N_WIDTH_DEF = 16;
   localparam int ACC_W       = Q_IN_DEF + N_WIDTH_DEF;

   typedef enum logic {
      IDLE = 1'b0,
      ACUM = 1'b1
   } state_t;

endpackage : lockin_pkg

// File: rtl/lockin_integrador.sv
// -----------------------------------------------------------------------------
// lockin_integrador
// Integrate-and-dump accumulator behind the lock-in product multiplier.
// Sums n_samples valid unsigned products into one frame result and emits it
// with a one-cycle valid pulse. In continuous mode the block re-arms on the
// dump edge itself, so back-to-back frames lose no samples.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset, clears all state
//   start          in   arms a frame when IDLE (ignored in ACUM)
//   stop           in   aborts the current frame, no output (wins over all)
//   continuo       in   re-arm automatically after each dump
//   n_samples      in   frame length, latched on start and on each re-arm
//   data_valid     in   qualifies data_in
//   data_in        in   unsigned product from the multiplier
//   data_out       out  unsigned frame sum, held until the next dump
//   data_out_valid out  one-cycle pulse per completed frame
//   busy           out  high while accumulating (state ACUM)
// -----------------------------------------------------------------------------
module lockin_integrador
   import lockin_pkg::*;
#(
   parameter int Q_IN    = Q_IN_DEF,
   parameter int N_WIDTH = N_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       continuo,
   input  logic [N_WIDTH-1:0]         n_samples,
   input  logic                       data_valid,
   input  logic [Q_IN-1:0]            data_in,
   output logic [Q_IN+N_WIDTH-1:0]    data_out,
   output logic                       data_out_valid,
   output logic                       busy
);

   // Wide enough for (2^N_WIDTH-1) products of full scale: no overflow.
   localparam int ACC_WIDTH = Q_IN + N_WIDTH;

   state_t                 state_reg,          state_next;
   logic [ACC_WIDTH-1:0]   acc_reg,            acc_next;
   logic [N_WIDTH-1:0]     cnt_reg,            cnt_next;
   logic [N_WIDTH-1:0]     n_len_reg,          n_len_next;
   logic [ACC_WIDTH-1:0]   data_out_reg,       data_out_next;
   logic                   data_out_valid_reg, data_out_valid_next;

   logic [ACC_WIDTH-1:0]   acc_sum;
   logic                   last_sample;

   assign acc_sum     = acc_reg + ACC_WIDTH'(data_in);
   // n_len is never 0 while in ACUM, so n_len-1 cannot wrap here.
   assign last_sample = (cnt_reg == (n_len_reg - N_WIDTH'(1)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg          <= IDLE;
         acc_reg            <= '0;
         cnt_reg            <= '0;
         n_len_reg          <= '0;
         data_out_reg       <= '0;
         data_out_valid_reg <= 1'b0;
      end else begin
         state_reg          <= state_next;
         acc_reg            <= acc_next;
         cnt_reg            <= cnt_next;
         n_len_reg          <= n_len_next;
         data_out_reg       <= data_out_next;
         data_out_valid_reg <= data_out_valid_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      acc_next            = acc_reg;
      cnt_next            = cnt_reg;
      n_len_next          = n_len_reg;
      data_out_next       = data_out_reg;
      data_out_valid_next = 1'b0;

      case (state_reg)
         IDLE: begin
            // stop has priority, so start+stop together leaves us idle.
            if (start && !stop) begin
               if (n_samples != '0) begin
                  n_len_next = n_samples;
                  acc_next   = '0;
                  cnt_next   = '0;
                  state_next = ACUM;
               end else begin
                  // Zero-length frame: immediate empty result, never arms.
                  data_out_next       = '0;
                  data_out_valid_next = 1'b1;
               end
            end
         end

         ACUM: begin
            if (stop) begin
               acc_next   = '0;
               cnt_next   = '0;
               state_next = IDLE;
            end else if (data_valid) begin
               if (last_sample) begin
                  data_out_next       = acc_sum;
                  data_out_valid_next = 1'b1;
                  acc_next            = '0;
                  cnt_next            = '0;
                  // A zero length cannot be accumulated in ACUM, so an
                  // auto re-arm with n_samples=0 drops back to IDLE instead.
                  if (continuo && (n_samples != '0)) begin
                     n_len_next = n_samples;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  acc_next = acc_sum;
                  cnt_next = cnt_reg + N_WIDTH'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign data_out       = data_out_reg;
   assign data_out_valid = data_out_valid_reg;
   assign busy           = (state_reg == ACUM);

endmodule : lockin_integrador

// File: tb/tb_lockin_integrador.sv
// -----------------------------------------------------------------------------
// tb_lockin_integrador
// Scoreboard bench: stimulus code sums the samples of each frame and, when it
// drives the last sample, queues the expected sum and the cycle at which the
// pulse must appear. An independent monitor pops and compares on every pulse.
// -----------------------------------------------------------------------------
module tb_lockin_integrador;

   localparam int QW = 30;
   localparam int NW = 16;
   localparam int AW = QW + NW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, stop, continuo, data_valid;
   logic [NW-1:0] n_samples;
   logic [QW-1:0] data_in;
   logic [AW-1:0] data_out;
   logic          data_out_valid;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [AW-1:0]   exp_q[$];
   int              exp_cyc_q[$];
   logic [AW-1:0]   last_out = '0;
   longint unsigned run_sum = 0;

   lockin_integrador #(.Q_IN(QW), .N_WIDTH(NW)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .continuo       (continuo),
      .n_samples      (n_samples),
      .data_valid     (data_valid),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .busy           (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint unsigned act, input longint unsigned expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: outputs are registered, so sampling on the falling edge is safe.
   always @(negedge clk) begin
      if (reset) begin
         last_out = '0;
      end else if (data_out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got data_out=%0d expected no pulse (cycle %0d)", data_out, cyc);
         end else begin
            check("frame_sum", longint'(data_out), longint'(exp_q.pop_front()));
            check("pulse_cycle", longint'(cyc), longint'(exp_cyc_q.pop_front()));
         end
         last_out = data_out;
      end else if (data_out !== last_out) begin
         total++;
         bad++;
         $display("FAIL data_out_hold: got %0d expected %0d (cycle %0d)", data_out, last_out, cyc);
      end
   end

   // Inputs change on the falling edge; the next rising edge samples them.
   task automatic drive(input logic st, input logic sp, input logic cont,
                        input logic dv, input logic [NW-1:0] ns, input logic [QW-1:0] d);
      @(negedge clk);
      start = st; stop = sp; continuo = cont; data_valid = dv;
      n_samples = ns; data_in = d;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // Pulse for a sample driven now must appear after the coming rising edge.
   task automatic push_exp(input longint unsigned v);
      exp_q.push_back(AW'(v));
      exp_cyc_q.push_back(cyc + 1);
   endtask

   task automatic sample(input logic st, input logic [QW-1:0] d, input bit last,
                         input logic cont, input logic [NW-1:0] ns);
      drive(st, 1'b0, cont, 1'b1, ns, d);
      run_sum += longint'(d);
      if (last) begin
         push_exp(run_sum);
         run_sum = 0;
      end
   endtask

   task automatic arm(input logic [NW-1:0] n);
      drive(1'b1, 1'b0, 1'b0, 1'b0, n, '0);
      run_sum = 0;
   endtask

   initial begin
      start = 0; stop = 0; continuo = 0; data_valid = 0; n_samples = '0; data_in = '0;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("reset_data_out", data_out, 0);
      check("reset_valid", data_out_valid, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;

      // Basic frame
      arm(16'd4);
      sample(0, 30'd1, 0, 0, 16'd4);
      check("basic_busy_after_start", busy, 1);
      sample(0, 30'd2, 0, 0, 16'd4);
      sample(0, 30'd3, 0, 0, 16'd4);
      sample(0, 30'd4, 1, 0, 16'd4);
      idle_cycle();
      check("basic_busy_after_dump", busy, 0);
      check("basic_value_10", data_out, 10);

      // Gapped valid
      arm(16'd3);
      sample(0, 30'd5, 0, 0, 16'd3);
      idle_cycle();
      idle_cycle();
      sample(0, 30'd6, 0, 0, 16'd3);
      sample(0, 30'd7, 1, 0, 16'd3);
      idle_cycle();
      check("gapped_value_18", data_out, 18);

      // Continuous: 3, 7, 11 with n=2, then n=3 applies only from the re-arm
      arm(16'd2);
      sample(0, 30'd1, 0, 1, 16'd2);
      sample(0, 30'd2, 1, 1, 16'd2);
      sample(0, 30'd3, 0, 1, 16'd2);
      sample(0, 30'd4, 1, 1, 16'd2);
      sample(0, 30'd5, 0, 1, 16'd3);
      sample(0, 30'd6, 1, 1, 16'd3);
      check("cont_busy_held", busy, 1);
      sample(0, 30'd7, 0, 1, 16'd3);
      sample(0, 30'd8, 0, 1, 16'd3);
      sample(0, 30'd9, 1, 0, 16'd3);
      idle_cycle();
      check("cont_busy_end", busy, 0);
      check("cont_last_value_24", data_out, 24);

      // Stop on last sample: no pulse, back to IDLE
      arm(16'd3);
      sample(0, 30'd1, 0, 0, 16'd3);
      sample(0, 30'd2, 0, 0, 16'd3);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 30'd3);
      run_sum = 0;
      idle_cycle();
      check("stop_busy", busy, 0);
      check("stop_no_pulse", data_out_valid, 0);

      // Start during ACUM is ignored (and its n_samples not latched)
      arm(16'd3);
      sample(0, 30'd1, 0, 0, 16'd3);
      sample(1, 30'd2, 0, 0, 16'd7);
      sample(0, 30'd3, 1, 0, 16'd7);
      idle_cycle();
      check("start_in_acum_busy", busy, 0);

      // start+stop in IDLE: stays IDLE
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd5, '0);
      idle_cycle();
      check("start_stop_idle_busy", busy, 0);

      // Reset mid-frame after 2 of 4 samples
      arm(16'd4);
      sample(0, 30'd9, 0, 0, 16'd4);
      sample(0, 30'd9, 0, 0, 16'd4);
      idle_cycle();
      reset = 1'b1;
      #1;
      check("midreset_data_out", data_out, 0);
      check("midreset_busy", busy, 0);
      check("midreset_valid", data_out_valid, 0);
      idle_cycle();
      reset = 1'b0;
      run_sum = 0;
      arm(16'd4);
      for (int i = 0; i < 4; i++) sample(0, 30'd1, i == 3, 0, 16'd4);
      idle_cycle();
      check("after_reset_value_4", data_out, 4);

      // Zero length: immediate zero pulse, never busy
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, '0);
      push_exp(0);
      idle_cycle();
      check("zero_len_busy_a", busy, 0);
      idle_cycle();
      check("zero_len_busy_b", busy, 0);

      // Randomized frames, with random gaps and random continuous chaining
      begin
         int unsigned n;
         int unsigned n_next;
         bit          cont;
         bit          armed = 0;
         n = $urandom_range(1, 6);
         for (int f = 0; f < 40; f++) begin
            if (!armed) arm(NW'(n));
            cont   = ($urandom_range(0, 1) == 1);
            n_next = $urandom_range(1, 6);
            for (int i = 0; i < int'(n); i++) begin
               int unsigned gaps = $urandom_range(0, 2);
               for (int g = 0; g < int'(gaps); g++)
                  drive(1'b0, 1'b0, cont, 1'b0, NW'(n_next), QW'($urandom));
               sample(0, QW'($urandom), i == int'(n) - 1, cont, NW'(n_next));
            end
            armed = cont;
            n     = n_next;
         end
         if (armed) begin
            // Close a pending continuous frame with continuo low.
            for (int i = 0; i < int'(n); i++)
               sample(0, QW'($urandom), i == int'(n) - 1, 0, NW'(n));
         end
         idle_cycle();
         check("random_busy_end", busy, 0);
      end

      // Max values: 65535 full-scale products, no wrap
      arm(16'hFFFF);
      for (int i = 0; i < 65535; i++)
         sample(0, {QW{1'b1}}, i == 65534, 0, 16'hFFFF);
      idle_cycle();
      check("max_value", data_out, 64'd65535 * ((64'd1 << 30) - 64'd1));

      for (int i = 0; i < 4; i++) idle_cycle();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lockin_integrador
